noc_router_xy: RTL and testbench

- Parametrised 5-port mesh router (Local, N, E, S, W) with per-input FIFOs, dimension-ordered XY routing and per-output round-robin arbitration.
- Next-generation building block for the `mesh` top: generalised in mesh size, flit width, buffer depth and node coordinate.
- Adds valid/ready back-pressure, out-of-range destination dropping and a global path-block stall.
- One instance per mesh node.

---
 rtl/noc_router_xy.sv | 191 +++++++++++++++++++
 tb/tb_noc_router_xy.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_router_xy.sv
// noc_router_xy: 5-port XY mesh router, per-input FIFOs and per-output round-robin output registers.
// Push-to-out_valid latency 2 cycles; in_ready = !full, output registers hold on !out_ready or block_all_paths.

module noc_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         empty,
   output logic         full
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));
endmodule

module noc_router_xy #(
   parameter int MESH_X    = 4,
   parameter int MESH_Y    = 4,
   parameter int MY_X      = 1,
   parameter int MY_Y      = 1,
   parameter int COORD_W   = 2,
   parameter int PAYLOAD_W = 7,
   parameter int DEPTH     = 4
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic [5*(2*COORD_W+PAYLOAD_W)-1:0]     in_flit,
   input  logic [4:0]                             in_valid,
   output logic [4:0]                             in_ready,
   output logic [5*(2*COORD_W+PAYLOAD_W)-1:0]     out_flit,
   output logic [4:0]                             out_valid,
   input  logic [4:0]                             out_ready,
   input  logic                                   block_all_paths,
   output logic [7:0]                             drop_count,
   output logic                                   route_err
);
   localparam int FLIT_W = 2*COORD_W + PAYLOAD_W;
   localparam int NP     = 5;
   localparam int P_L    = 0;
   localparam int P_N    = 1;
   localparam int P_E    = 2;
   localparam int P_S    = 3;
   localparam int P_W    = 4;
   localparam logic [31:0] LIM_X = 32'(MESH_X);
   localparam logic [31:0] LIM_Y = 32'(MESH_Y);
   localparam logic [31:0] POS_X = 32'(MY_X);
   localparam logic [31:0] POS_Y = 32'(MY_Y);

   typedef struct packed {
      logic [COORD_W-1:0]   dst_x;
      logic [COORD_W-1:0]   dst_y;
      logic [PAYLOAD_W-1:0] payload;
   } flit_t;

   flit_t         head     [NP];
   flit_t         out_dat  [NP];
   flit_t         load_dat [NP];
   logic [NP-1:0] req      [NP];
   logic [NP-1:0] grant    [NP];
   logic [2:0]    rr_ptr   [NP];
   logic [2:0]    rr_nxt   [NP];
   logic [NP-1:0] empty, full, push, pop, drop, free, load, out_vld;
   logic [2:0]    ndrop;
   logic [8:0]    dsum;

   function automatic logic [2:0] rr_pos(input logic [2:0] base, input int k);
      logic [3:0] s;
      s = {1'b0, base} + 4'(k);
      return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
   endfunction

   assign push      = in_valid & ~full;
   assign in_ready  = ~full;
   assign out_valid = out_vld & {NP{~block_all_paths}};
   assign route_err = |drop;

   for (genvar p = 0; p < NP; p++) begin : g_port
      noc_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
         .clock     (clock),
         .reset     (reset),
         .push      (push[p]),
         .push_data (in_flit[p*FLIT_W +: FLIT_W]),
         .pop       (pop[p]),
         .head      (head[p]),
         .empty     (empty[p]),
         .full      (full[p])
      );
      assign out_flit[p*FLIT_W +: FLIT_W] = out_dat[p];
   end

   // XY routing: X is resolved before Y; out-of-mesh destinations are dropped.
   always_comb begin
      drop = '0;
      for (int o = 0; o < NP; o++) req[o] = '0;
      for (int i = 0; i < NP; i++) begin
         if (!empty[i]) begin
            if (32'(head[i].dst_x) >= LIM_X || 32'(head[i].dst_y) >= LIM_Y) drop[i] = 1'b1;
            else if (32'(head[i].dst_x) > POS_X) req[P_E][i] = 1'b1;
            else if (32'(head[i].dst_x) < POS_X) req[P_W][i] = 1'b1;
            else if (32'(head[i].dst_y) > POS_Y) req[P_S][i] = 1'b1;
            else if (32'(head[i].dst_y) < POS_Y) req[P_N][i] = 1'b1;
            else                                  req[P_L][i] = 1'b1;
         end
      end
   end

   always_comb begin
      free = '0;
      load = '0;
      for (int o = 0; o < NP; o++) begin
         grant[o]    = '0;
         load_dat[o] = '0;
         rr_nxt[o]   = rr_ptr[o];
         free[o]     = !out_vld[o] || (out_valid[o] && out_ready[o]);
         if (!block_all_paths && free[o]) begin
            for (int k = 0; k < NP; k++) begin
               for (int i = 0; i < NP; i++) begin
                  if (!load[o] && req[o][i] && rr_pos(rr_ptr[o], k) == 3'(i)) begin
                     load[o]     = 1'b1;
                     grant[o][i] = 1'b1;
                     load_dat[o] = head[i];
                     rr_nxt[o]   = (i == NP-1) ? 3'd0 : 3'(i + 1);
                  end
               end
            end
         end
      end
   end

   always_comb begin
      pop   = drop;
      ndrop = '0;
      for (int i = 0; i < NP; i++) begin
         pop   = pop | grant[i];
         ndrop = ndrop + 3'(drop[i]);
      end
   end

   assign dsum = {1'b0, drop_count} + {6'd0, ndrop};

   always_ff @(posedge clock) begin
      if (reset) begin
         out_vld    <= '0;
         drop_count <= '0;
         for (int o = 0; o < NP; o++) begin
            out_dat[o] <= '0;
            rr_ptr[o]  <= '0;
         end
      end else begin
         for (int o = 0; o < NP; o++) begin
            if (load[o]) begin
               out_dat[o] <= load_dat[o];
               out_vld[o] <= 1'b1;
               rr_ptr[o]  <= rr_nxt[o];
            end else if (out_valid[o] && out_ready[o]) begin
               out_vld[o] <= 1'b0;
            end
         end
         drop_count <= dsum[8] ? 8'hFF : dsum[7:0];
      end
   end
endmodule

// File: tb/tb_noc_router_xy.sv
// Bench for noc_router_xy: 4x4 instance checked against a queue-based model every cycle,
// plus a 3-column instance for out-of-range dropping.

module tb_noc_router_xy;
   logic        clock;
   logic        reset;
   logic [54:0] in_flit;
   logic [4:0]  in_valid, in_ready, out_valid, out_ready;
   logic [54:0] out_flit;
   logic        blk;
   logic [7:0]  drop_count;
   logic        route_err;

   logic [54:0] s_in_flit;
   logic [4:0]  s_in_valid, s_in_ready, s_out_valid;
   logic [54:0] s_out_flit;
   logic [7:0]  s_drop_count;
   logic        s_route_err;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   bit chk_en = 0;

   logic [10:0] mq [5][$];
   bit          mov [5];
   logic [10:0] mdat [5];
   int          mrr [5];
   int          mdrop;

   logic [10:0] seen [5][$];
   int          seen_cyc [5][$];

   noc_router_xy dut (
      .clock(clock), .reset(reset), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
      .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
      .block_all_paths(blk), .drop_count(drop_count), .route_err(route_err)
   );

   noc_router_xy #(.MESH_X(3)) dut_small (
      .clock(clock), .reset(reset), .in_flit(s_in_flit), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .out_flit(s_out_flit), .out_valid(s_out_valid), .out_ready(5'h1F),
      .block_all_paths(1'b0), .drop_count(s_drop_count), .route_err(s_route_err)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [10:0] mkf(input int x, input int y, input logic [6:0] pl);
      return {2'(x), 2'(y), pl};
   endfunction

   // Destination port for the 4x4 mesh node at (1,1); -1 means dropped.
   function automatic int route_of(input logic [10:0] f);
      int x, y;
      x = int'(f[10:9]);
      y = int'(f[8:7]);
      if (x >= 4 || y >= 4) return -1;
      if (x > 1) return 2;
      if (x < 1) return 4;
      if (y > 1) return 3;
      if (y < 1) return 1;
      return 0;
   endfunction

   always @(posedge clock) begin
      bit popm [5];
      bit rdy [5];
      bit got;
      int nd;
      if (reset) begin
         for (int o = 0; o < 5; o++) begin
            mq[o].delete();
            mov[o] = 0;
            mdat[o] = '0;
            mrr[o] = 0;
         end
         mdrop = 0;
      end else begin
         nd = 0;
         for (int i = 0; i < 5; i++) begin
            popm[i] = 0;
            rdy[i] = mq[i].size() < 4;
            if (mq[i].size() > 0 && route_of(mq[i][0]) < 0) begin
               popm[i] = 1;
               nd++;
            end
         end
         if (!blk) begin
            for (int o = 0; o < 5; o++) begin
               if (!mov[o] || out_ready[o]) begin
                  got = 0;
                  for (int k = 0; k < 5; k++) begin
                     int i;
                     i = (mrr[o] + k) % 5;
                     if (!got && mq[i].size() > 0 && route_of(mq[i][0]) == o) begin
                        got = 1;
                        mdat[o] = mq[i][0];
                        popm[i] = 1;
                        mrr[o] = (i + 1) % 5;
                     end
                  end
                  mov[o] = got;
               end
            end
         end
         for (int i = 0; i < 5; i++) if (popm[i]) void'(mq[i].pop_front());
         for (int i = 0; i < 5; i++) if (in_valid[i] && rdy[i]) mq[i].push_back(in_flit[i*11 +: 11]);
         mdrop = (mdrop + nd > 255) ? 255 : mdrop + nd;
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         logic [4:0] exp_rdy;
         bit exp_err;
         exp_err = 0;
         for (int o = 0; o < 5; o++) begin
            bit ev;
            ev = mov[o] && !blk;
            check($sformatf("model out_valid[%0d]", o), 32'(out_valid[o]), 32'(ev));
            if (ev) check($sformatf("model out_flit[%0d]", o), 32'(out_flit[o*11 +: 11]), 32'(mdat[o]));
            exp_rdy[o] = mq[o].size() < 4;
            if (mq[o].size() > 0 && route_of(mq[o][0]) < 0) exp_err = 1;
         end
         check("model in_ready", 32'(in_ready), 32'(exp_rdy));
         check("model drop_count", 32'(drop_count), mdrop);
         check("model route_err", 32'(route_err), 32'(exp_err));
      end
   end

   always @(negedge clock) begin
      for (int o = 0; o < 5; o++) begin
         if (out_valid[o] && out_ready[o]) begin
            seen[o].push_back(out_flit[o*11 +: 11]);
            seen_cyc[o].push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1;
      in_valid = '0;
      s_in_valid = '0;
      blk = 0;
      out_ready = 5'h1F;
      tick();
      reset = 0;
      for (int o = 0; o < 5; o++) begin
         seen[o].delete();
         seen_cyc[o].delete();
      end
   endtask

   task automatic send_one(input int src, input logic [10:0] f, input int exp_port, input string nm);
      in_flit[src*11 +: 11] = f;
      in_valid = 5'(1 << src);
      tick();
      in_valid = '0;
      @(negedge clock);
      check({nm, " early out_valid"}, 32'(out_valid), 0);
      tick();
      @(negedge clock);
      check({nm, " out_valid"}, 32'(out_valid), 32'(1 << exp_port));
      check({nm, " out_flit"}, 32'(out_flit[exp_port*11 +: 11]), 32'(f));
      tick();
   endtask

   task automatic test_contention();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         in_flit[1*11 +: 11] = mkf(3, 1, 7'(8'h10 + k));
         in_flit[3*11 +: 11] = mkf(3, 1, 7'(8'h20 + k));
         in_flit[4*11 +: 11] = mkf(3, 1, 7'(8'h30 + k));
         in_valid = 5'b11010;
         tick();
      end
      in_valid = '0;
      repeat (14) tick();
      check("rr count", seen[2].size(), 12);
      if (seen[2].size() == 12) begin
         for (int j = 0; j < 12; j++)
            check($sformatf("rr order %0d", j), 32'(seen[2][j]),
                  32'(mkf(3, 1, 7'(8'h10 * (j % 3 + 1) + j / 3))));
         check("rr back-to-back", seen_cyc[2][11] - seen_cyc[2][0], 11);
      end
   endtask

   task automatic test_backpressure();
      int acc;
      logic a;
      do_reset();
      out_ready = 5'b11011;
      acc = 0;
      for (int it = 0; it < 9; it++) begin
         in_flit[4*11 +: 11] = mkf(3, 1, 7'(8'h40 + acc));
         in_valid = 5'b10000;
         a = in_ready[4];
         tick();
         if (a) begin
            acc++;
            if (acc == 5) check("bp in_ready after 5th", 32'(in_ready[4]), 0);
         end
      end
      in_valid = '0;
      @(negedge clock);
      check("bp accepted", acc, 5);
      check("bp held valid", 32'(out_valid[2]), 1);
      check("bp held flit", 32'(out_flit[22 +: 11]), 32'(mkf(3, 1, 7'h40)));
      check("bp nothing out", seen[2].size(), 0);
      tick();
      out_ready = 5'h1F;
      repeat (8) tick();
      check("bp drained", seen[2].size(), 5);
      if (seen[2].size() == 5)
         for (int j = 0; j < 5; j++)
            check($sformatf("bp order %0d", j), 32'(seen[2][j]), 32'(mkf(3, 1, 7'(8'h40 + j))));
   endtask

   task automatic test_drop();
      int acc;
      logic a;
      do_reset();
      s_in_flit[0 +: 11] = mkf(3, 0, 7'h11);
      s_in_valid = 5'b00001;
      tick();
      s_in_valid = '0;
      @(negedge clock);
      check("drop route_err pulse", 32'(s_route_err), 1);
      check("drop count before pop", 32'(s_drop_count), 0);
      tick();
      @(negedge clock);
      check("drop route_err end", 32'(s_route_err), 0);
      check("drop count one", 32'(s_drop_count), 1);
      check("drop no output", 32'(s_out_valid), 0);
      s_in_flit[0 +: 11] = mkf(3, 2, 7'h12);
      s_in_flit[11 +: 11] = mkf(3, 3, 7'h13);
      s_in_valid = 5'b00011;
      tick();
      s_in_valid = '0;
      @(negedge clock);
      check("dual drop route_err", 32'(s_route_err), 1);
      tick();
      @(negedge clock);
      check("dual drop count", 32'(s_drop_count), 3);
      acc = 0;
      s_in_flit[0 +: 11] = mkf(3, 1, 7'h7F);
      for (int it = 0; it < 400 && acc < 300; it++) begin
         s_in_valid = 5'b00001;
         a = s_in_ready[0];
         tick();
         if (a) acc++;
      end
      s_in_valid = '0;
      repeat (3) tick();
      @(negedge clock);
      check("drop stream accepted", acc, 300);
      check("drop saturate", 32'(s_drop_count), 255);
      check("drop idle route_err", 32'(s_route_err), 0);
      check("drop idle out_valid", 32'(s_out_valid), 0);
   endtask

   task automatic test_block_and_reset();
      do_reset();
      in_flit[0 +: 11] = mkf(3, 1, 7'h61);
      in_valid = 5'b00001;
      tick();
      in_valid = '0;
      tick();
      blk = 1;
      for (int j = 0; j < 10; j++) begin
         in_flit[0 +: 11] = mkf(3, 1, 7'(8'h62 + j));
         in_valid = (j < 2) ? 5'b00001 : 5'b00000;
         @(negedge clock);
         check($sformatf("block out_valid %0d", j), 32'(out_valid), 0);
         tick();
      end
      in_valid = '0;
      check("block nothing out", seen[2].size(), 0);
      blk = 0;
      @(negedge clock);
      check("unblock valid", 32'(out_valid), 32'(5'b00100));
      check("unblock flit", 32'(out_flit[22 +: 11]), 32'(mkf(3, 1, 7'h61)));
      repeat (5) tick();
      check("unblock count", seen[2].size(), 3);
      if (seen[2].size() == 3)
         for (int j = 0; j < 3; j++)
            check($sformatf("unblock order %0d", j), 32'(seen[2][j]), 32'(mkf(3, 1, 7'(8'h61 + j))));
      out_ready = 5'b11011;
      for (int j = 0; j < 3; j++) begin
         in_flit[0 +: 11] = mkf(3, 1, 7'(8'h70 + j));
         in_valid = 5'b00001;
         tick();
      end
      in_valid = '0;
      @(negedge clock);
      check("midreset pending valid", 32'(out_valid[2]), 1);
      reset = 1;
      tick();
      reset = 0;
      @(negedge clock);
      check("midreset out_valid", 32'(out_valid), 0);
      check("midreset in_ready", 32'(in_ready), 32'(5'h1F));
      out_ready = 5'h1F;
      repeat (4) tick();
      check("midreset nothing emitted", seen[2].size(), 3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clock = 0;
      reset = 1;
      in_flit = '0;
      s_in_flit = '0;
      in_valid = '0;
      s_in_valid = '0;
      out_ready = 5'h1F;
      blk = 0;
      do_reset();
      chk_en = 1;
      @(negedge clock);
      check("reset in_ready", 32'(in_ready), 32'(5'h1F));
      check("reset out_valid", 32'(out_valid), 0);
      check("reset out_flit", 32'(out_flit), 0);
      check("reset drop_count", 32'(drop_count), 0);
      check("reset route_err", 32'(route_err), 0);

      send_one(0, mkf(3, 1, 7'h55), 2, "t1 L->E");
      check("t1 literal flit", 32'(seen[2].size() > 0 ? seen[2][0] : 11'h0), 32'h6D5);
      send_one(0, mkf(1, 1, 7'h01), 0, "sweep L");
      send_one(0, mkf(1, 0, 7'h02), 1, "sweep N");
      send_one(0, mkf(1, 3, 7'h03), 3, "sweep S");
      send_one(0, mkf(0, 2, 7'h04), 4, "sweep W");

      test_contention();
      test_backpressure();
      test_drop();
      test_block_and_reset();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
